// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: clear codes,
// FSM state encodings and the bundled control word driven to the datapath.
package hazard_ctrl_pkg;

   // Pipeline register clear codes (2'b10 is never driven)
   localparam logic [1:0] CLR_NORMAL = 2'b00;
   localparam logic [1:0] CLR_STALL  = 2'b01;
   localparam logic [1:0] CLR_FLUSH  = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_MWAIT = 2'd1,
      ST_REDIR = 2'd2
   } state_t;

   typedef struct packed {
      logic       pc_en;
      logic [1:0] ifid;
      logic [1:0] idex;
      logic [1:0] exmem;
      logic [1:0] memwb;
   } ctrl_t;

   function automatic ctrl_t mk_ctrl(input logic       pc,
                                     input logic [1:0] ifid,
                                     input logic [1:0] idex,
                                     input logic [1:0] exmem,
                                     input logic [1:0] memwb);
      ctrl_t c;
      c.pc_en = pc;
      c.ifid  = ifid;
      c.idex  = idex;
      c.exmem = exmem;
      c.memwb = memwb;
      return c;
   endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard controller performance counters.
// Holds at all-ones once reached; cleared by synchronous reset.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   // Count up on inc, stick at all-ones
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller. Drives PC write enable and the clear codes of
// the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Outputs are Mealy: decoded
// from the current state and inputs. Priority: memory wait > redirect >
// load-use > normal.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int REDIRECT_BUBBLES = 1,
   parameter int MEM_TIMEOUT      = 64,
   parameter int CNT_W            = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_redirect,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic [1:0]       clr_ifid,
   output logic [1:0]       clr_idex,
   output logic [1:0]       clr_exmem,
   output logic [1:0]       clr_memwb,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   // Wait counter starts at 0 on the second wait cycle, so the abort cycle
   // (wait cycle number MEM_TIMEOUT) sees a count of MEM_TIMEOUT-2.
   localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;
   localparam int BUB_W  = $clog2(REDIRECT_BUBBLES) + 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 2);
   localparam logic [BUB_W-1:0]  BUB_RELOAD = BUB_W'(REDIRECT_BUBBLES - 1);

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic [BUB_W-1:0]  bub_cnt;

   logic  load_use;
   logic  mem_wait;
   logic  timeout_hit;
   logic  redir_take;
   ctrl_t ctrl;

   // Hazard detection: load-use compare and memory wait / timeout qualification
   always_comb begin
      load_use = ex_mem_read && (ex_rd != 5'd0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
      mem_wait    = (state == ST_MWAIT) ? !mem_ready : (mem_req && !mem_ready);
      timeout_hit = (state == ST_MWAIT) && !mem_ready && (wait_cnt == WAIT_LAST);
      redir_take  = !mem_wait && ex_redirect;
   end

   // Output decode in priority order; reset forces a full flush with PC frozen
   always_comb begin
      ctrl = mk_ctrl(1'b1, CLR_NORMAL, CLR_NORMAL, CLR_NORMAL, CLR_NORMAL);
      if (rst) begin
         ctrl = mk_ctrl(1'b0, CLR_FLUSH, CLR_FLUSH, CLR_FLUSH, CLR_FLUSH);
      end else if (mem_wait) begin
         ctrl = mk_ctrl(1'b0, CLR_STALL, CLR_STALL,
                        timeout_hit ? CLR_FLUSH : CLR_STALL, CLR_FLUSH);
      end else if (ex_redirect) begin
         ctrl = mk_ctrl(1'b1, CLR_FLUSH, CLR_FLUSH, CLR_NORMAL, CLR_NORMAL);
      end else if (state == ST_REDIR) begin
         ctrl = mk_ctrl(1'b1, CLR_FLUSH, CLR_NORMAL, CLR_NORMAL, CLR_NORMAL);
      end else if (load_use) begin
         ctrl = mk_ctrl(1'b0, CLR_STALL, CLR_FLUSH, CLR_NORMAL, CLR_NORMAL);
      end
   end

   assign pc_en     = ctrl.pc_en;
   assign clr_ifid  = ctrl.ifid;
   assign clr_idex  = ctrl.idex;
   assign clr_exmem = ctrl.exmem;
   assign clr_memwb = ctrl.memwb;

   // FSM: memory wait tracking, redirect bubble countdown and sticky timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_RUN;
         wait_cnt    <= '0;
         bub_cnt     <= '0;
         mem_timeout <= 1'b0;
      end else if (mem_wait) begin
         // A wait entered from REDIR abandons the remaining bubbles
         bub_cnt <= '0;
         if (timeout_hit) begin
            state       <= ST_RUN;
            mem_timeout <= 1'b1;
         end else if (state != ST_MWAIT) begin
            state    <= ST_MWAIT;
            wait_cnt <= '0;
         end else begin
            wait_cnt <= wait_cnt + 1'b1;
         end
      end else if (ex_redirect) begin
         if (REDIRECT_BUBBLES > 1) begin
            state   <= ST_REDIR;
            bub_cnt <= BUB_RELOAD;
         end else begin
            state <= ST_RUN;
         end
      end else if (state == ST_REDIR) begin
         bub_cnt <= bub_cnt - 1'b1;
         if (bub_cnt == BUB_W'(1)) begin
            state <= ST_RUN;
         end
      end else begin
         state <= ST_RUN;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!rst && !ctrl.pc_en),
      .count (stall_cycles)
   );

   sat_counter #(.CNT_W(CNT_W)) u_redir_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!rst && redir_take),
      .count (redirect_count)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

   localparam int RB = 3;
   localparam int MT = 4;
   localparam int CW = 8;
   localparam int CMAX = (1 << CW) - 1;

   // {pc_en, ifid, idex, exmem, memwb}
   localparam logic [8:0] P_NORM  = 9'b1_00_00_00_00;
   localparam logic [8:0] P_RST   = 9'b0_11_11_11_11;
   localparam logic [8:0] P_LU    = 9'b0_01_11_00_00;
   localparam logic [8:0] P_WAIT  = 9'b0_01_01_01_11;
   localparam logic [8:0] P_TO    = 9'b0_01_01_11_11;
   localparam logic [8:0] P_REDIR = 9'b1_11_11_00_00;
   localparam logic [8:0] P_BUB   = 9'b1_11_00_00_00;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;
   logic          pc_en, mem_timeout;
   logic [1:0]    clr_ifid, clr_idex, clr_exmem, clr_memwb;
   logic [CW-1:0] stall_cycles, redirect_count;
   logic [8:0]    obs;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign obs = {pc_en, clr_ifid, clr_idex, clr_exmem, clr_memwb};

   hazard_ctrl #(.REDIRECT_BUBBLES(RB), .MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .ex_rd          (ex_rd),
      .ex_mem_read    (ex_mem_read),
      .ex_redirect    (ex_redirect),
      .mem_req        (mem_req),
      .mem_ready      (mem_ready),
      .pc_en          (pc_en),
      .clr_ifid       (clr_ifid),
      .clr_idex       (clr_idex),
      .clr_exmem      (clr_exmem),
      .clr_memwb      (clr_memwb),
      .mem_timeout    (mem_timeout),
      .stall_cycles   (stall_cycles),
      .redirect_count (redirect_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = 5'd0; ex_mem_read = 1'b0; ex_redirect = 1'b0;
      mem_req = 1'b0; mem_ready = 1'b0;
   endtask

   task automatic set_load_use();
      ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 1'b1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      #4;
      checks++; if (obs !== P_RST) begin errors++; $display("FAIL reset_outs got %b exp %b", obs, P_RST); end
      checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cycles); end
      checks++; if (redirect_count !== '0) begin errors++; $display("FAIL reset_redir got %0d exp 0", redirect_count); end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", mem_timeout); end
      tick();
      rst = 1'b0;
      #4;
      checks++; if (obs !== P_NORM) begin errors++; $display("FAIL post_reset_idle got %b exp %b", obs, P_NORM); end
      tick();
      checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL post_reset_stall got %0d exp 0", stall_cycles); end
   endtask

   task automatic test_load_use();
      do_reset();
      ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      id_rs1 = 5'd7; id_use_rs1 = 1'b1;
      #4;
      checks++; if (obs !== P_LU) begin errors++; $display("FAIL lu_rs2 got %b exp %b", obs, P_LU); end
      tick();
      checks++; if (stall_cycles !== CW'(1)) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cycles); end
      ex_rd = 5'd0; id_rs2 = 5'd0;
      #4;
      checks++; if (obs !== P_NORM) begin errors++; $display("FAIL lu_rd_zero got %b exp %b", obs, P_NORM); end
      tick();
      ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b0;
      #4;
      checks++; if (obs !== P_NORM) begin errors++; $display("FAIL lu_unused_rs2 got %b exp %b", obs, P_NORM); end
      tick();
      id_rs1 = 5'd5;
      #4;
      checks++; if (obs !== P_LU) begin errors++; $display("FAIL lu_rs1 got %b exp %b", obs, P_LU); end
      tick();
      ex_mem_read = 1'b0;
      #4;
      checks++; if (obs !== P_NORM) begin errors++; $display("FAIL lu_not_load got %b exp %b", obs, P_NORM); end
      tick();
      idle_inputs();
   endtask

   task automatic test_mem_wait();
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #4;
         checks++; if (obs !== P_WAIT) begin errors++; $display("FAIL wait_cycle%0d got %b exp %b", i, obs, P_WAIT); end
         tick();
      end
      mem_ready = 1'b1;
      #4;
      checks++; if (obs !== P_NORM) begin errors++; $display("FAIL wait_release got %b exp %b", obs, P_NORM); end
      tick();
      idle_inputs();
      #4;
      checks++; if (obs !== P_NORM) begin errors++; $display("FAIL wait_after got %b exp %b", obs, P_NORM); end
      checks++; if (stall_cycles !== CW'(3)) begin errors++; $display("FAIL wait_stall_cnt got %0d exp 3", stall_cycles); end
      tick();
   endtask

   task automatic test_redirect();
      do_reset();
      ex_redirect = 1'b1;
      #4;
      checks++; if (obs !== P_REDIR) begin errors++; $display("FAIL redir_first got %b exp %b", obs, P_REDIR); end
      tick();
      ex_redirect = 1'b0;
      for (int i = 0; i < RB - 1; i++) begin
         if (i == 1) set_load_use();
         #4;
         checks++; if (obs !== P_BUB) begin errors++; $display("FAIL redir_bubble%0d got %b exp %b", i, obs, P_BUB); end
         tick();
      end
      idle_inputs();
      #4;
      checks++; if (obs !== P_NORM) begin errors++; $display("FAIL redir_done got %b exp %b", obs, P_NORM); end
      checks++; if (redirect_count !== CW'(1)) begin errors++; $display("FAIL redir_cnt got %0d exp 1", redirect_count); end
      tick();
   endtask

   task automatic test_wait_priority();
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0; ex_redirect = 1'b1;
      set_load_use();
      for (int i = 0; i < 2; i++) begin
         #4;
         checks++; if (obs !== P_WAIT) begin errors++; $display("FAIL prio_wait%0d got %b exp %b", i, obs, P_WAIT); end
         tick();
      end
      checks++; if (redirect_count !== '0) begin errors++; $display("FAIL prio_redir_cnt got %0d exp 0", redirect_count); end
      mem_ready = 1'b1;
      #4;
      checks++; if (obs !== P_REDIR) begin errors++; $display("FAIL prio_ready_redir got %b exp %b", obs, P_REDIR); end
      tick();
      checks++; if (redirect_count !== CW'(1)) begin errors++; $display("FAIL prio_ready_cnt got %0d exp 1", redirect_count); end
      idle_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      mem_req = 1'b1; mem_ready = 1'b0;
      for (int i = 0; i < MT - 1; i++) begin
         #4;
         checks++; if (obs !== P_WAIT) begin errors++; $display("FAIL to_wait%0d got %b exp %b", i, obs, P_WAIT); end
         tick();
      end
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_early got %b exp 0", mem_timeout); end
      #4;
      checks++; if (obs !== P_TO) begin errors++; $display("FAIL to_abort got %b exp %b", obs, P_TO); end
      tick();
      checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", mem_timeout); end
      idle_inputs();
      for (int i = 0; i < 5; i++) begin
         #4;
         checks++; if (obs !== P_NORM) begin errors++; $display("FAIL to_after%0d got %b exp %b", i, obs, P_NORM); end
         tick();
      end
      checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", mem_timeout); end
      do_reset();
      checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_cleared got %b exp 0", mem_timeout); end
   endtask

   task automatic test_saturation();
      do_reset();
      set_load_use();
      for (int i = 0; i < CMAX + 40; i++) tick();
      checks++; if (stall_cycles !== CW'(CMAX)) begin errors++; $display("FAIL sat_stall got %0d exp %0d", stall_cycles, CMAX); end
      idle_inputs();
      ex_redirect = 1'b1;
      for (int i = 0; i < CMAX + 40; i++) tick();
      checks++; if (redirect_count !== CW'(CMAX)) begin errors++; $display("FAIL sat_redir got %0d exp %0d", redirect_count, CMAX); end
      checks++; if (stall_cycles !== CW'(CMAX)) begin errors++; $display("FAIL sat_stall_hold got %0d exp %0d", stall_cycles, CMAX); end
      idle_inputs();
   endtask

   // Behavioural model: tracks how long the current memory wait has lasted
   // and how many post-redirect flush cycles remain.
   task automatic test_random();
      bit         m_in_wait = 1'b0;
      int         m_wait_len = 0;
      int         m_bubbles = 0;
      int         m_stall = 0;
      int         m_redir = 0;
      bit         m_to = 1'b0;
      logic [8:0] exp;
      bit         waiting, lu;
      int         this_wait;
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         rst         = ($urandom_range(63) == 0);
         mem_req     = ($urandom_range(2) == 0);
         mem_ready   = $urandom_range(1) == 1;
         ex_redirect = ($urandom_range(5) == 0);
         ex_mem_read = $urandom_range(1) == 1;
         ex_rd       = 5'($urandom_range(3));
         id_rs1      = 5'($urandom_range(3));
         id_rs2      = 5'($urandom_range(3));
         id_use_rs1  = $urandom_range(1) == 1;
         id_use_rs2  = $urandom_range(1) == 1;
         lu = ex_mem_read && (ex_rd != 0) &&
              ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
         waiting = m_in_wait ? !mem_ready : (mem_req && !mem_ready);
         if (rst) begin
            exp = P_RST;
            m_in_wait = 0; m_wait_len = 0; m_bubbles = 0; m_stall = 0; m_redir = 0; m_to = 0;
         end else if (waiting) begin
            this_wait = m_in_wait ? m_wait_len + 1 : 1;
            m_bubbles = 0;
            if (m_in_wait && this_wait == MT) begin
               exp = P_TO; m_to = 1; m_in_wait = 0;
            end else begin
               exp = P_WAIT; m_in_wait = 1; m_wait_len = this_wait;
            end
         end else begin
            m_in_wait = 0;
            if (ex_redirect) begin
               exp = P_REDIR; m_bubbles = RB - 1;
               if (m_redir < CMAX) m_redir++;
            end else if (m_bubbles > 0) begin
               exp = P_BUB; m_bubbles--;
            end else if (lu) begin
               exp = P_LU;
            end else begin
               exp = P_NORM;
            end
         end
         if (!rst && exp[8] == 1'b0 && m_stall < CMAX) m_stall++;
         #4;
         checks++; if (obs !== exp) begin errors++; $display("FAIL rand_outs cyc %0d got %b exp %b", n, obs, exp); end
         tick();
         checks++; if (stall_cycles !== CW'(m_stall)) begin errors++; $display("FAIL rand_stall cyc %0d got %0d exp %0d", n, stall_cycles, m_stall); end
         checks++; if (redirect_count !== CW'(m_redir)) begin errors++; $display("FAIL rand_redir cyc %0d got %0d exp %0d", n, redirect_count, m_redir); end
         checks++; if (mem_timeout !== m_to) begin errors++; $display("FAIL rand_timeout cyc %0d got %b exp %b", n, mem_timeout, m_to); end
      end
      rst = 1'b0;
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_load_use();
      test_mem_wait();
      test_redirect();
      test_wait_priority();
      test_timeout();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
